// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Moore-style main control FSM for a multicycle RV32 subset datapath.
// The state register is the only storage; all datapath controls are decoded
// from the registered state (plus mem_ready in FETCH and the branch condition
// in BRANCH). While rst is high the write enables are forced low.
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int MEM_HANDSHAKE = 1,  // 1: memory states wait for mem_ready
    parameter int ENABLE_U      = 1   // 1: lui/auipc are legal instructions
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] immsrc,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);

    // Opcodes understood by the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic U_EN = (ENABLE_U != 0);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_AUIPC    = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    // Branch condition: only beq/bne are implemented, everything else falls through
    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
        logic t;
        case (f3)
            3'b000:  t = z;
            3'b001:  t = ~z;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Immediate format selection, purely a function of the opcode
    function automatic logic [2:0] imm_decode(input logic [6:0] o);
        logic [2:0] f;
        case (o)
            OP_LOAD, OP_ITYPE: f = 3'b000;
            OP_STORE:          f = 3'b001;
            OP_BRANCH:         f = 3'b010;
            OP_JAL:            f = 3'b011;
            OP_LUI, OP_AUIPC:  f = 3'b100;
            default:           f = 3'b000;
        endcase
        return f;
    endfunction

    // State that follows DECODE for a given opcode; unknown opcodes trap
    function automatic state_t decode_next(input logic [6:0] o, input logic u_en);
        state_t n;
        case (o)
            OP_LOAD, OP_STORE: n = S_MEMADR;
            OP_RTYPE:          n = S_EXECR;
            OP_ITYPE:          n = S_EXECI;
            OP_BRANCH:         n = S_BRANCH;
            OP_JAL:            n = S_JAL;
            OP_LUI:            n = u_en ? S_LUI : S_TRAP;
            OP_AUIPC:          n = u_en ? S_AUIPC : S_TRAP;
            default:           n = S_TRAP;
        endcase
        return n;
    endfunction

    state_t     state_q;
    state_t     state_d;
    logic       mem_ok_s;
    logic       pcwrite_s;
    logic       irwrite_s;
    logic       memwrite_s;
    logic       regwrite_s;
    logic       illegal_s;

    // Without a handshake the memory is assumed to answer every cycle
    assign mem_ok_s = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // State register with asynchronous reset to FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ok_s ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = decode_next(op, U_EN);
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ok_s ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ok_s ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI,
            S_JAL,
            S_LUI,
            S_AUIPC:    state_d = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BRANCH:   state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;  // unused encodings recover
        endcase
    end

    // Per-state control decode; every output defaults to 0
    always_comb begin
        pcwrite_s  = 1'b0;
        adrsrc     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        illegal_s  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite_s = mem_ok_s;
                pcwrite_s = mem_ok_s;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regwrite_s = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
            end
            S_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
            end
            S_BRANCH: begin
                alusrca   = 2'b10;
                aluop     = 2'b01;
                pcwrite_s = branch_taken(funct3, zero);
            end
            S_JAL: begin
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                pcwrite_s = 1'b1;
            end
            S_LUI: begin
                alusrca = 2'b11;
                alusrcb = 2'b01;
            end
            S_AUIPC: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            S_TRAP: begin
                illegal_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b0;
            end
        endcase
    end

    // Enables are killed for the whole reset pulse, not just after the edge
    assign pcwrite  = pcwrite_s  & ~rst;
    assign irwrite  = irwrite_s  & ~rst;
    assign memwrite = memwrite_s & ~rst;
    assign regwrite = regwrite_s & ~rst;
    assign illegal  = illegal_s  & ~rst;

    assign immsrc = imm_decode(op);
    assign state  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// Table-driven bench for multicycle_controller. Each row is one clock cycle:
// inputs applied just after a rising edge, outputs compared mid-cycle.
// Rows flagged alt drive a second instance built with ENABLE_U=0 and
// MEM_HANDSHAKE=0 while the main instance is held in reset (and vice versa).
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    // Control vector layout:
    // {pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc, alusrca, alusrcb, aluop, illegal}
    localparam logic [13:0] C_FETCH1   = 14'b10100_10_00_10_00_0;
    localparam logic [13:0] C_FETCH0   = 14'b00000_10_00_10_00_0;
    localparam logic [13:0] C_DECODE   = 14'b00000_00_01_01_00_0;
    localparam logic [13:0] C_MEMADR   = 14'b00000_00_10_01_00_0;
    localparam logic [13:0] C_MEMREAD  = 14'b01000_00_00_00_00_0;
    localparam logic [13:0] C_MEMWB    = 14'b00001_01_00_00_00_0;
    localparam logic [13:0] C_MEMWRITE = 14'b01010_00_00_00_00_0;
    localparam logic [13:0] C_EXECR    = 14'b00000_00_10_00_10_0;
    localparam logic [13:0] C_EXECI    = 14'b00000_00_10_01_10_0;
    localparam logic [13:0] C_ALUWB    = 14'b00001_00_00_00_00_0;
    localparam logic [13:0] C_BR_T     = 14'b10000_00_10_00_01_0;
    localparam logic [13:0] C_BR_N     = 14'b00000_00_10_00_01_0;
    localparam logic [13:0] C_JAL      = 14'b10000_00_01_10_00_0;
    localparam logic [13:0] C_LUI      = 14'b00000_00_11_01_00_0;
    localparam logic [13:0] C_AUIPC    = 14'b00000_00_01_01_00_0;
    localparam logic [13:0] C_TRAP     = 14'b00000_00_00_00_00_1;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] AUI  = 7'b0010111;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pcwrite, adrsrc, irwrite, memwrite, regwrite, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb, aluop;
    logic [2:0] immsrc;
    logic [3:0] state;

    logic       a_rst;
    logic [6:0] a_op;
    logic       a_mr;
    logic       a_pcwrite, a_adrsrc, a_irwrite, a_memwrite, a_regwrite, a_illegal;
    logic [1:0] a_resultsrc, a_alusrca, a_alusrcb, a_aluop;
    logic [2:0] a_immsrc;
    logic [3:0] a_state;

    logic [13:0] ctl_s;
    logic [13:0] a_ctl_s;

    int checks = 0;
    int errors = 0;

    multicycle_controller u_dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct3    (funct3),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pcwrite   (pcwrite),
        .adrsrc    (adrsrc),
        .irwrite   (irwrite),
        .memwrite  (memwrite),
        .regwrite  (regwrite),
        .resultsrc (resultsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .immsrc    (immsrc),
        .aluop     (aluop),
        .illegal   (illegal),
        .state     (state)
    );

    multicycle_controller #(.MEM_HANDSHAKE(0), .ENABLE_U(0)) u_alt (
        .clk       (clk),
        .rst       (a_rst),
        .op        (a_op),
        .funct3    (funct3),
        .zero      (zero),
        .mem_ready (a_mr),
        .pcwrite   (a_pcwrite),
        .adrsrc    (a_adrsrc),
        .irwrite   (a_irwrite),
        .memwrite  (a_memwrite),
        .regwrite  (a_regwrite),
        .resultsrc (a_resultsrc),
        .alusrca   (a_alusrca),
        .alusrcb   (a_alusrcb),
        .immsrc    (a_immsrc),
        .aluop     (a_aluop),
        .illegal   (a_illegal),
        .state     (a_state)
    );

    assign ctl_s   = {pcwrite, adrsrc, irwrite, memwrite, regwrite,
                      resultsrc, alusrca, alusrcb, aluop, illegal};
    assign a_ctl_s = {a_pcwrite, a_adrsrc, a_irwrite, a_memwrite, a_regwrite,
                      a_resultsrc, a_alusrca, a_alusrcb, a_aluop, a_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          alt;
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [13:0] ctl;
        logic [2:0]  imm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit alt, input logic r, input logic [6:0] o, input logic [2:0] f,
                       input logic z, input logic mr, input logic [3:0] st,
                       input logic [13:0] c, input logic [2:0] im);
        vec_t v;
        v.alt = alt; v.rst = r; v.op = o; v.f3 = f; v.zero = z; v.mr = mr;
        v.st = st; v.ctl = c; v.imm = im;
        vecs.push_back(v);
    endtask

    task automatic m_row(input logic r, input logic [6:0] o, input logic [2:0] f, input logic z,
                         input logic mr, input logic [3:0] st, input logic [13:0] c,
                         input logic [2:0] im);
        add(1'b0, r, o, f, z, mr, st, c, im);
    endtask

    task automatic a_row(input logic r, input logic [6:0] o, input logic [3:0] st,
                         input logic [13:0] c, input logic [2:0] im);
        add(1'b1, r, o, 3'b000, 1'b0, 1'b0, st, c, im);
    endtask

    task automatic chk(input string name, input int row, input logic [13:0] got,
                       input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %b expected %b", row, name, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; op = LW; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
        a_rst = 1'b1; a_op = LW; a_mr = 1'b0;

        // reset, then lw with mem_ready high: 0,1,2,3,4
        m_row(1'b1, LW, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH0, 3'b000);
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b000);
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b000);
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b1, 4'd2, C_MEMADR, 3'b000);
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b1, 4'd3, C_MEMREAD, 3'b000);
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b1, 4'd4, C_MEMWB, 3'b000);
        // sw with two wait cycles in MEMWRITE
        m_row(1'b0, SW, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b001);
        m_row(1'b0, SW, 3'b000, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b001);
        m_row(1'b0, SW, 3'b000, 1'b0, 1'b1, 4'd2, C_MEMADR, 3'b001);
        m_row(1'b0, SW, 3'b000, 1'b0, 1'b0, 4'd5, C_MEMWRITE, 3'b001);
        m_row(1'b0, SW, 3'b000, 1'b0, 1'b0, 4'd5, C_MEMWRITE, 3'b001);
        m_row(1'b0, SW, 3'b000, 1'b0, 1'b1, 4'd5, C_MEMWRITE, 3'b001);
        // R-type
        m_row(1'b0, RT, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b000);
        m_row(1'b0, RT, 3'b000, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b000);
        m_row(1'b0, RT, 3'b000, 1'b0, 1'b1, 4'd6, C_EXECR, 3'b000);
        m_row(1'b0, RT, 3'b000, 1'b0, 1'b1, 4'd8, C_ALUWB, 3'b000);
        // I-type
        m_row(1'b0, IT, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b000);
        m_row(1'b0, IT, 3'b000, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b000);
        m_row(1'b0, IT, 3'b000, 1'b0, 1'b1, 4'd7, C_EXECI, 3'b000);
        m_row(1'b0, IT, 3'b000, 1'b0, 1'b1, 4'd8, C_ALUWB, 3'b000);
        // beq taken, beq not taken, bne taken, funct3=100 never taken
        m_row(1'b0, BR, 3'b000, 1'b1, 1'b1, 4'd0, C_FETCH1, 3'b010);
        m_row(1'b0, BR, 3'b000, 1'b1, 1'b1, 4'd1, C_DECODE, 3'b010);
        m_row(1'b0, BR, 3'b000, 1'b1, 1'b1, 4'd9, C_BR_T, 3'b010);
        m_row(1'b0, BR, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b010);
        m_row(1'b0, BR, 3'b000, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b010);
        m_row(1'b0, BR, 3'b000, 1'b0, 1'b1, 4'd9, C_BR_N, 3'b010);
        m_row(1'b0, BR, 3'b001, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b010);
        m_row(1'b0, BR, 3'b001, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b010);
        m_row(1'b0, BR, 3'b001, 1'b0, 1'b1, 4'd9, C_BR_T, 3'b010);
        m_row(1'b0, BR, 3'b100, 1'b1, 1'b1, 4'd0, C_FETCH1, 3'b010);
        m_row(1'b0, BR, 3'b100, 1'b1, 1'b1, 4'd1, C_DECODE, 3'b010);
        m_row(1'b0, BR, 3'b100, 1'b1, 1'b1, 4'd9, C_BR_N, 3'b010);
        // jal, lui, auipc
        m_row(1'b0, JAL, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b011);
        m_row(1'b0, JAL, 3'b000, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b011);
        m_row(1'b0, JAL, 3'b000, 1'b0, 1'b1, 4'd10, C_JAL, 3'b011);
        m_row(1'b0, JAL, 3'b000, 1'b0, 1'b1, 4'd8, C_ALUWB, 3'b011);
        m_row(1'b0, LUI, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b100);
        m_row(1'b0, LUI, 3'b000, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b100);
        m_row(1'b0, LUI, 3'b000, 1'b0, 1'b1, 4'd11, C_LUI, 3'b100);
        m_row(1'b0, LUI, 3'b000, 1'b0, 1'b1, 4'd8, C_ALUWB, 3'b100);
        m_row(1'b0, AUI, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b100);
        m_row(1'b0, AUI, 3'b000, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b100);
        m_row(1'b0, AUI, 3'b000, 1'b0, 1'b1, 4'd12, C_AUIPC, 3'b100);
        m_row(1'b0, AUI, 3'b000, 1'b0, 1'b1, 4'd8, C_ALUWB, 3'b100);
        // fetch stall for one cycle
        m_row(1'b0, RT, 3'b000, 1'b0, 1'b0, 4'd0, C_FETCH0, 3'b000);
        m_row(1'b0, RT, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b000);
        m_row(1'b0, RT, 3'b000, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b000);
        m_row(1'b0, RT, 3'b000, 1'b0, 1'b1, 4'd6, C_EXECR, 3'b000);
        m_row(1'b0, RT, 3'b000, 1'b0, 1'b1, 4'd8, C_ALUWB, 3'b000);
        // illegal opcode traps and holds; reset releases it
        m_row(1'b0, BAD, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b000);
        m_row(1'b0, BAD, 3'b000, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b000);
        m_row(1'b0, BAD, 3'b000, 1'b0, 1'b1, 4'd13, C_TRAP, 3'b000);
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b1, 4'd13, C_TRAP, 3'b000);
        m_row(1'b1, LW, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH0, 3'b000);
        // lw stalled in MEMREAD, reset mid-wait
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b000);
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b000);
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b1, 4'd2, C_MEMADR, 3'b000);
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b0, 4'd3, C_MEMREAD, 3'b000);
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b0, 4'd3, C_MEMREAD, 3'b000);
        m_row(1'b1, LW, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH0, 3'b000);
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b1, 4'd0, C_FETCH1, 3'b000);
        m_row(1'b0, LW, 3'b000, 1'b0, 1'b1, 4'd1, C_DECODE, 3'b000);

        // alt instance: mem_ready held low (ignored), U-type disabled
        a_row(1'b1, LW, 4'd0, C_FETCH0, 3'b000);
        a_row(1'b0, LW, 4'd0, C_FETCH1, 3'b000);
        a_row(1'b0, LW, 4'd1, C_DECODE, 3'b000);
        a_row(1'b0, LW, 4'd2, C_MEMADR, 3'b000);
        a_row(1'b0, LW, 4'd3, C_MEMREAD, 3'b000);
        a_row(1'b0, LW, 4'd4, C_MEMWB, 3'b000);
        a_row(1'b0, LUI, 4'd0, C_FETCH1, 3'b100);
        a_row(1'b0, LUI, 4'd1, C_DECODE, 3'b100);
        a_row(1'b0, LUI, 4'd13, C_TRAP, 3'b100);
        a_row(1'b0, LUI, 4'd13, C_TRAP, 3'b100);
        a_row(1'b1, SW, 4'd0, C_FETCH0, 3'b001);
        a_row(1'b0, SW, 4'd0, C_FETCH1, 3'b001);
        a_row(1'b0, SW, 4'd1, C_DECODE, 3'b001);
        a_row(1'b0, SW, 4'd2, C_MEMADR, 3'b001);
        a_row(1'b0, SW, 4'd5, C_MEMWRITE, 3'b001);
        a_row(1'b0, AUI, 4'd0, C_FETCH1, 3'b100);
        a_row(1'b0, AUI, 4'd1, C_DECODE, 3'b100);
        a_row(1'b0, AUI, 4'd13, C_TRAP, 3'b100);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].alt) begin
                rst   = 1'b1;
                a_rst = vecs[i].rst;
                a_op  = vecs[i].op;
                a_mr  = vecs[i].mr;
            end else begin
                a_rst     = 1'b1;
                rst       = vecs[i].rst;
                op        = vecs[i].op;
                funct3    = vecs[i].f3;
                zero      = vecs[i].zero;
                mem_ready = vecs[i].mr;
            end
            #2;
            if (vecs[i].alt) begin
                chk("alt state", i, {10'd0, a_state}, {10'd0, vecs[i].st});
                chk("alt controls", i, a_ctl_s, vecs[i].ctl);
                chk("alt immsrc", i, {11'd0, a_immsrc}, {11'd0, vecs[i].imm});
            end else begin
                chk("state", i, {10'd0, state}, {10'd0, vecs[i].st});
                chk("controls", i, ctl_s, vecs[i].ctl);
                chk("immsrc", i, {11'd0, immsrc}, {11'd0, vecs[i].imm});
            end
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1; 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready, 0 = mem_ready ignored and treated as 1.
REQ-002 SHALL have parameter ENABLE_U, default 1; 1 = lui (0110111) and auipc (0010111) legal, 0 = both illegal.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- op  in  7  opcode of current instruction
- funct3  in  3  branch condition select
- zero  in  1  ALU result zero flag
- mem_ready  in  1  memory access complete this cycle
- pcwrite  out  1  PC register enable
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  instruction register enable
- memwrite  out  1  data memory write enable
- regwrite  out  1  register file write enable
- resultsrc  out  2  result mux: 00 = ALUOut, 01 = read data, 10 = ALU result
- alusrca  out  2  ALU A: 00 = PC, 01 = oldPC, 10 = rs1, 11 = constant 0
- alusrcb  out  2  ALU B: 00 = rs2, 01 = immediate, 10 = constant 4
- immsrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- aluop  out  2  00 add, 01 subtract/compare, 10 funct-decoded
- illegal  out  1  high while in TRAP
- state  out  4  current state encoding (debug)

Function
REQ-005 SHALL implement Moore FSM states with encodings FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, AUIPC 12, TRAP 13; encodings 14–15 SHALL go to FETCH on the next cycle.
REQ-006 Transitions:
- FETCH -> DECODE when mem_ready, else stay.
- DECODE by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 0110111 -> LUI; 0010111 -> AUIPC; any other op -> TRAP.
- MEMADR -> MEMREAD if op = 0000011, else MEMWRITE.
- MEMREAD -> MEMWB when mem_ready, else stay.
- MEMWRITE -> FETCH when mem_ready, else stay.
- EXECR, EXECI, JAL, LUI, AUIPC -> ALUWB.
- MEMWB, ALUWB, BRANCH -> FETCH.
- TRAP -> TRAP until rst.
REQ-007 Per-state outputs; any output not listed SHALL be 0:
- FETCH: adrsrc 0, alusrca 00, alusrcb 10, resultsrc 10, aluop 00; irwrite and pcwrite equal mem_ready.
- DECODE: alusrca 01, alusrcb 01, aluop 00.
- MEMADR: alusrca 10, alusrcb 01, aluop 00.
- MEMREAD: adrsrc 1.
- MEMWB: resultsrc 01, regwrite 1.
- MEMWRITE: adrsrc 1, memwrite 1, held until mem_ready.
- EXECR: alusrca 10, alusrcb 00, aluop 10.
- EXECI: alusrca 10, alusrcb 01, aluop 10.
- ALUWB: resultsrc 00, regwrite 1.
- BRANCH: alusrca 10, alusrcb 00, aluop 01, resultsrc 00; pcwrite = taken.
- JAL: alusrca 01, alusrcb 10, resultsrc 00, pcwrite 1.
- LUI: alusrca 11, alusrcb 01.
- AUIPC: alusrca 01, alusrcb 01.
- TRAP: illegal 1; all enables 0.
REQ-008 Branch taken SHALL be: funct3 000 = zero; 001 = ~zero; any other funct3 = not taken, with no trap.
REQ-009 immsrc SHALL be decoded combinationally from op in every state: lw/addi = 000, sw = 001, branch = 010, jal = 011, lui/auipc = 100, otherwise 000.
REQ-010 With ENABLE_U = 0, ops 0110111 and 0010111 SHALL go DECODE -> TRAP.
REQ-011 With MEM_HANDSHAKE = 0, FETCH, MEMREAD and MEMWRITE SHALL each last exactly one cycle.
REQ-012 Minimum cycle counts with mem_ready tied high: lw 5, sw 4, R/I/jal/lui/auipc 4, branch 3.

Reset
REQ-013 rst high SHALL asynchronously set state to FETCH and force pcwrite, irwrite, memwrite, regwrite and illegal to 0 while rst is high.
REQ-014 Reset asserted mid-instruction (any state, including TRAP or a memory wait) SHALL abandon the instruction; after rst falls, the next rising edge evaluates FETCH.

Verification
REQ-015 lw (op 0000011), mem_ready = 1 -> state sequence 0,1,2,3,4,0; regwrite = 1 only in state 4, with resultsrc = 01.
REQ-016 sw, mem_ready low for 2 cycles in MEMWRITE -> memwrite = 1 for 3 cycles, then state 0; regwrite never 1.
REQ-017 beq: zero = 1 -> pcwrite = 1 in BRANCH; zero = 0 -> pcwrite = 0. bne with zero = 0 -> pcwrite = 1.
REQ-018 op 1111111 -> states 0,1,13; illegal = 1 and held; rst pulse -> state 0 and illegal = 0.
REQ-019 lui with ENABLE_U = 1 -> states 0,1,11,8,0, with alusrca = 11 and immsrc = 100; with ENABLE_U = 0 -> TRAP.
REQ-020 rst asserted during MEMREAD wait -> state 0 immediately, all enables 0.
